puf_pair_reader: RTL and testbench

Controller that reads a pair of configurable ring-oscillator count channels and turns them into a PUF response. For each response bit it applies one 6-bit challenge slice to both oscillator channels, resets their counters, enables both for a fixed clock-cycle window, freezes them, synchronizes the frozen counts and compares them. It sits between the challenge source (switches/host) and two oscillator-plus-counter instances, and drives the response register read by the display/readout logic.

---
 rtl/puf_pkg.sv | 23 ++
 rtl/puf_phase_timer.sv | 35 +++
 rtl/puf_pair_reader.sv | 202 ++++++++++++++++++++
 tb/tb_puf_pair_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared types and constants for the ring-oscillator PUF pair reader.
//   state_t  - controller states
//   CHAL_W   - challenge bits per response bit ({bx, sel})
//   COUNT_W  - oscillator counter width
//   SEL_LSB / BX_LSB / FIELD_W - field positions inside one challenge slice
package puf_pkg;

  localparam int CHAL_W  = 6;
  localparam int COUNT_W = 16;
  localparam int FIELD_W = 3;
  localparam int SEL_LSB = 0;
  localparam int BX_LSB  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

endpackage

// File: rtl/puf_phase_timer.sv
// puf_phase_timer: loadable down-counter timing one controller phase.
//   clk, reset  - clock, synchronous active-high reset
//   i_load      - start a new phase; has priority over an expiring one
//   i_len       - phase length in cycles minus one
//   o_expired   - high during the last cycle of the loaded phase
// A load at edge t makes o_expired rise in cycle t+len (len = i_len+1).
module puf_phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_len,
  output logic          o_expired
);

  logic [TW-1:0] r_cnt;
  logic          r_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= i_len;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) r_active <= 1'b0;
      else             r_cnt    <= r_cnt - 1'b1;
    end
  end

  assign o_expired = r_active && (r_cnt == '0);

endmodule

// File: rtl/puf_pair_reader.sv
// puf_pair_reader: drives two ring-oscillator counter channels with one
// challenge slice per response bit, runs them for a fixed window, then
// synchronizes and compares the frozen counts into the response register.
//   clk, reset            - clock, synchronous active-high reset
//   start                 - begin an evaluation (accepted only when idle)
//   challenge             - RESP_BITS slices of {bx[2:0], sel[2:0]}
//   count_a, count_b      - oscillator counts, asynchronous to clk
//   ro_enable, ro_reset   - run / clear control to both oscillators
//   ro_sel, ro_bx         - oscillator configuration for the current bit
//   busy, done            - evaluation in progress / one-cycle completion
//   response, sat         - response bits, sticky saturated-count flag
// Optional build macro PUF_MARGIN_EN adds output `unstable`, flagging bits
// whose count difference is within MARGIN.
module puf_pair_reader
  import puf_pkg::*;
#(
  parameter int RESP_BITS     = 8,
  parameter int WINDOW        = 100000,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int MARGIN        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CHAL_W*RESP_BITS-1:0] challenge,
  input  logic [COUNT_W-1:0]          count_a,
  input  logic [COUNT_W-1:0]          count_b,
  output logic                        ro_enable,
  output logic                        ro_reset,
  output logic [FIELD_W-1:0]          ro_sel,
  output logic [FIELD_W-1:0]          ro_bx,
  output logic                        busy,
  output logic                        done,
  output logic [RESP_BITS-1:0]        response,
  output logic                        sat
`ifdef PUF_MARGIN_EN
  ,
  output logic [RESP_BITS-1:0]        unstable
`endif
);

  localparam int MAXLEN =
    (WINDOW > CLEAR_CYCLES)
      ? ((WINDOW > SETTLE_CYCLES) ? WINDOW : SETTLE_CYCLES)
      : ((CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES);
  localparam int TW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [TW-1:0]    LEN_CLEAR  = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0]    LEN_RUN    = TW'(WINDOW - 1);
  localparam logic [TW-1:0]    LEN_SETTLE = TW'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RESP_BITS - 1);

  if (RESP_BITS < 1 || WINDOW < 1 || CLEAR_CYCLES < 1 || SETTLE_CYCLES < 3 || MARGIN < 0)
  begin : g_bad_param
    $error("puf_pair_reader: parameter out of range");
  end

  function automatic logic f_is_sat(input logic [COUNT_W-1:0] c);
    return &c;
  endfunction

  state_t                      r_state, w_next;
  logic                        w_load, w_expired;
  logic [TW-1:0]               w_len;
  logic [CHAL_W*RESP_BITS-1:0] r_chal;
  logic [IDX_W-1:0]            r_idx, w_nidx;
  logic [CHAL_W-1:0]           w_nslice;
  logic [FIELD_W-1:0]          r_sel, r_bx;
  logic [RESP_BITS-1:0]        r_resp;
  logic                        r_sat;
  logic [COUNT_W-1:0]          r_a_p0, r_a_p1, r_b_p0, r_b_p1;

  puf_phase_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_len     (w_len),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Each phase transition reloads the timer with the length of the phase
  // being entered, in the same cycle the previous phase expires.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_len  = LEN_CLEAR;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_next = S_CLEAR;
        w_load = 1'b1;
        w_len  = LEN_CLEAR;
      end
      S_CLEAR: if (w_expired) begin
        w_next = S_RUN;
        w_load = 1'b1;
        w_len  = LEN_RUN;
      end
      S_RUN: if (w_expired) begin
        w_next = S_SETTLE;
        w_load = 1'b1;
        w_len  = LEN_SETTLE;
      end
      S_SETTLE: if (w_expired) w_next = S_COMPARE;
      S_COMPARE: begin
        if (r_idx == LAST_IDX) begin
          w_next = S_DONE;
        end else begin
          w_next = S_CLEAR;
          w_load = 1'b1;
          w_len  = LEN_CLEAR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counter reset is held in IDLE and DONE as well so the oscillators stay
  // cleared between evaluations.
  assign ro_enable = (r_state == S_RUN);
  assign ro_reset  = (r_state == S_IDLE) || (r_state == S_CLEAR) || (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign ro_sel    = r_sel;
  assign ro_bx     = r_bx;
  assign response  = r_resp;
  assign sat       = r_sat;

  // Stage p0/p1: two-flop synchronizer for the asynchronous counts
  always_ff @(posedge clk) begin
    r_a_p0 <= count_a;
    r_b_p0 <= count_b;
    r_a_p1 <= r_a_p0;
    r_b_p1 <= r_b_p0;
  end

  // w_nidx wraps on the last bit; the slice is only used when another bit follows.
  assign w_nidx   = r_idx + 1'b1;
  assign w_nslice = r_chal[int'(w_nidx)*CHAL_W +: CHAL_W];

`ifdef PUF_MARGIN_EN
  function automatic logic [COUNT_W:0] f_absdiff(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    logic signed [COUNT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d;
  endfunction

  logic [RESP_BITS-1:0] r_unstable;
  assign unstable = r_unstable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_unstable <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_unstable <= '0;
    end else if (r_state == S_COMPARE) begin
      r_unstable[r_idx] <= (f_absdiff(r_a_p1, r_b_p1) <= (COUNT_W+1)'(MARGIN));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= '0;
      r_sel  <= '0;
      r_bx   <= '0;
      r_resp <= '0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_chal <= challenge;
          r_idx  <= '0;
          r_resp <= '0;
          r_sat  <= 1'b0;
          r_sel  <= challenge[SEL_LSB +: FIELD_W];
          r_bx   <= challenge[BX_LSB +: FIELD_W];
        end
        S_COMPARE: begin
          r_resp[r_idx] <= (r_a_p1 > r_b_p1);
          r_sat         <= r_sat | f_is_sat(r_a_p1) | f_is_sat(r_b_p1);
          if (r_idx != LAST_IDX) begin
            r_idx <= w_nidx;
            r_sel <= w_nslice[SEL_LSB +: FIELD_W];
            r_bx  <= w_nslice[BX_LSB +: FIELD_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_pair_reader.sv
// Bench for puf_pair_reader: a behavioural oscillator model feeds counts,
// a scoreboard queue holds the expected result of each accepted evaluation,
// and a monitor checks it whenever done is presented.
module tb_puf_pair_reader;

  localparam int RB  = 4;
  localparam int WIN = 16;
  localparam int CLR = 2;
  localparam int SET = 3;
  localparam int MRG = 16;
  localparam int PER = CLR + WIN + SET + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [RB*6-1:0] challenge = '0;
  logic [15:0]     count_a = '0;
  logic [15:0]     count_b = '0;
  logic            ro_enable, ro_reset, busy, done, sat;
  logic [2:0]      ro_sel, ro_bx;
  logic [RB-1:0]   response;
`ifdef PUF_MARGIN_EN
  logic [RB-1:0]   unstable;
`endif

  puf_pair_reader #(
    .RESP_BITS(RB), .WINDOW(WIN), .CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET), .MARGIN(MRG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .count_a(count_a), .count_b(count_b),
    .ro_enable(ro_enable), .ro_reset(ro_reset), .ro_sel(ro_sel), .ro_bx(ro_bx),
    .busy(busy), .done(done), .response(response), .sat(sat)
`ifdef PUF_MARGIN_EN
    , .unstable(unstable)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [RB-1:0] resp;
    logic          sat;
    logic [RB-1:0] unst;
    int            dcyc;
  } exp_t;

  exp_t          sb[$];
  int            A[RB];
  int            B[RB];
  logic [RB*6-1:0] cur_chal = '0;

  // Reference: response bit = A>B, sat if any count is all-ones,
  // unstable if the absolute difference is within the margin.
  function automatic exp_t model(input int dcyc);
    exp_t e;
    e.resp = '0;
    e.sat  = 1'b0;
    e.unst = '0;
    for (int i = 0; i < RB; i++) begin
      e.resp[i] = (A[i] > B[i]);
      if (A[i] == 65535 || B[i] == 65535) e.sat = 1'b1;
      e.unst[i] = (((A[i] > B[i]) ? A[i] - B[i] : B[i] - A[i]) <= MRG);
    end
    e.dcyc = dcyc;
    return e;
  endfunction

  // Oscillator pair: cleared while ro_reset, ramps while enabled, and when
  // the window closes the counters hold the per-bit final values A/B.
  int   obit = 0;
  int   en_cnt = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    logic [5:0] sl;
    if (ro_reset && !busy) obit = 0;
    if (ro_reset) begin
      count_a = '0;
      count_b = '0;
    end
    if (ro_enable) begin
      if (!prev_en) begin
        en_cnt = 0;
        if (obit < RB) begin
          sl = cur_chal[obit*6 +: 6];
          chk("ro_sel", ro_sel, sl[2:0]);
          chk("ro_bx", ro_bx, sl[5:3]);
        end else begin
          chk("extra_bit", obit, RB - 1);
        end
      end
      en_cnt++;
      count_a = 16'(en_cnt * 3);
      count_b = 16'(en_cnt * 2 + 1);
    end else if (prev_en && busy) begin
      chk("enable_len", en_cnt, WIN);
      if (obit < RB) begin
        count_a = 16'(A[obit]);
        count_b = 16'(B[obit]);
      end
      obit++;
    end
    prev_en = ro_enable;
  end

  // Monitor
  logic busy_fall_due = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_fall_due) begin
      chk("busy_after_done", busy, 1'b0);
      busy_fall_due = 1'b0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("response", response, e.resp);
        chk("sat", sat, e.sat);
        chk("done_cycle", cyc, e.dcyc);
`ifdef PUF_MARGIN_EN
        chk("unstable", unstable, e.unst);
`endif
        busy_fall_due = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic start_eval(input logic [RB*6-1:0] ch);
    wait_idle();
    @(negedge clk);
    challenge = ch;
    cur_chal  = ch;
    start     = 1'b1;
    sb.push_back(model(cyc + 1 + RB * PER));
    @(negedge clk);
    start     = 1'b0;
    challenge = RB*6'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < RB * PER + 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bit(input int b, input string name);
    int n = 0;
    while (!(obit == b && ro_enable) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, obit, b);
  endtask

  task automatic fill(input int a, input int b);
    for (int i = 0; i < RB; i++) begin
      A[i] = a;
      B[i] = b;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int mode;
    // reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ro_enable", ro_enable, 1'b0);
    chk("rst_ro_reset", ro_reset, 1'b1);
    chk("rst_ro_sel", ro_sel, 3'd0);
    chk("rst_ro_bx", ro_bx, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_response", response, '0);
    chk("rst_sat", sat, 1'b0);

    // a > b on every bit
    fill(100, 50);
    start_eval(24'hABCDEF);
    wait_done();

    // ties
    fill(77, 77);
    start_eval(RB*6'($urandom));
    wait_done();

    // large but clear difference
    fill(200, 100);
    start_eval(RB*6'($urandom));
    wait_done();

    // saturated count on bit 2 only
    fill(30, 20);
    B[2] = 65535;
    start_eval(RB*6'($urandom));
    wait_bit(3, "sat_reach_bit3");
    repeat (5) @(negedge clk);
    chk("sat_after_bit2", sat, 1'b1);
    wait_done();
    repeat (4) @(negedge clk);
    chk("sat_held_idle", sat, 1'b1);

    // start pulsed while busy is ignored
    fill(5, 9);
    A[1] = 40;
    start_eval(24'h123456);
    repeat (30) @(negedge clk);
    challenge = 24'hFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset during RUN of bit 1 (bit 0 already compared as 1)
    fill(90, 10);
    start_eval(RB*6'($urandom));
    wait_bit(1, "reach_bit1");
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ro_enable", ro_enable, 1'b0);
    chk("midrst_ro_reset", ro_reset, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_response", response, '0);
    reset = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);

    // randomized evaluations
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < RB; i++) begin
        mode = int'($urandom_range(0, 3));
        A[i] = int'($urandom_range(0, 1000));
        case (mode)
          0:       B[i] = A[i];
          1:       B[i] = A[i] + int'($urandom_range(0, 40)) - 20;
          2:       B[i] = int'($urandom_range(0, 65535));
          default: B[i] = 65535;
        endcase
        if (B[i] < 0) B[i] = 0;
      end
      start_eval(RB*6'($urandom));
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
